fetch_unit: RTL



---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/fetch_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int INSTR_W    = 32;
    localparam int ILEN_BYTES = 4;
    localparam int PC_W       = 64;  // widest PC a buffered entry can carry
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries with flush and occupancy.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               push_entry,
    input  logic                       pop,
    output fetch_entry_t               head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign occupancy = count;
    assign head      = mem[rd_ptr];

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            if (do_push) wr_ptr <= bump(wr_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_entry;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        (push && full && !flush) |-> pop);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC generation, credit-limited in-order imem requests,
// response drop after redirects, and a small buffer feeding IF/ID.
// Optional perf counters are compiled in with `define FETCH_PERF_CNT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                  PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int                  DEPTH    = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [PC_WIDTH-1:0] imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [INSTR_W-1:0]  imem_rsp_data,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    input  logic                stall,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]         perf_drop_cnt,
    output logic [31:0]         perf_stall_cnt,
`endif
    output logic                if_valid,
    output logic [INSTR_W-1:0]  if_instr,
    output logic [PC_WIDTH-1:0] if_pc
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(ILEN_BYTES);

    logic [PC_WIDTH-1:0] pc, rsp_pc, target_pc;
    logic [CNT_W-1:0]    outstanding, drop_cnt, occupancy;
    logic                run;
    logic                credit_ok, accept, rsp_drop, push, pop, empty, full;
    logic                redirect_lsb_unused;
    fetch_entry_t        push_entry, head;

    assign target_pc           = {redirect_pc[PC_WIDTH-1:2], 2'b00};
    assign redirect_lsb_unused = ^redirect_pc[1:0];

    // Every slot is reserved at request time, so buffered + in-flight never exceeds DEPTH.
    assign credit_ok      = ({1'b0, occupancy} + {1'b0, outstanding}) < (CNT_W+1)'(DEPTH);
    assign imem_req_valid = run && !redirect_valid && credit_ok;
    assign imem_req_addr  = pc;
    assign accept         = imem_req_valid && imem_req_ready;

    assign rsp_drop = redirect_valid || (drop_cnt != '0);
    assign push     = imem_rsp_valid && !rsp_drop;
    assign pop      = if_valid && !stall && !redirect_valid;

    // Surviving responses are consecutive from the last restart point, so a
    // single running PC labels each pushed word.
    assign push_entry.pc    = PC_W'(rsp_pc);
    assign push_entry.instr = imem_rsp_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run         <= 1'b0;
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            run         <= 1'b1;
            outstanding <= outstanding + CNT_W'(accept) - CNT_W'(imem_rsp_valid);
            if (redirect_valid) begin
                pc       <= target_pc;
                rsp_pc   <= target_pc;
                drop_cnt <= outstanding - CNT_W'(imem_rsp_valid);
            end else begin
                if (accept) pc <= pc + PC_STEP;
                if (push)   rsp_pc <= rsp_pc + PC_STEP;
                if (imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CNT_W'(1);
            end
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (redirect_valid),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .empty      (empty),
        .full       (full),
        .occupancy  (occupancy)
    );

    assign if_valid = !empty;
    assign if_instr = empty ? NOP_INSTR : head.instr;
    assign if_pc    = empty ? '0 : head.pc[PC_WIDTH-1:0];

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_drop_cnt  <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (imem_rsp_valid && rsp_drop && perf_drop_cnt != 32'hFFFFFFFF)
                perf_drop_cnt <= perf_drop_cnt + 32'd1;
            if (if_valid && stall && perf_stall_cnt != 32'hFFFFFFFF)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

    a_rsp_expected: assert property (@(posedge clk) disable iff (!reset_n)
        imem_rsp_valid |-> (outstanding != '0));
    a_full_unused: assert property (@(posedge clk) disable iff (!reset_n)
        full |-> (occupancy == CNT_W'(DEPTH)));

endmodule
